// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Takes the EX/MEM load/store request,
// runs it on a req/gnt/rvalid data bus, builds byte enables and store lane
// replication, formats load data and holds the pipeline until completion.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [2:0]  mem_op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misalign_out,
  output logic        bus_err_out,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  // Last RSP cycle index before the access is declared timed out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic        access, misaligned, start, timeout;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata_fmt;

  // Captured access, held stable for the whole bus transaction.
  logic        we_q;
  logic [1:0]  lo_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic [31:0] load_data_q;

  // Decode the incoming request; reset gates it so nothing input-driven
  // (stall, misalign) can assert while rstn is low.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    access     = rstn & (mem_rd_in | mem_wr_in);
    misaligned = 1'b0;
    case (mem_op_in)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr_in[0];
      3'b010:         misaligned = |addr_in[1:0];
      default:        misaligned = 1'b1;   // reserved op is rejected like a misalignment
    endcase
    start = access & ~misaligned;
  end

  // Store formatting: byte enables and lane replication by access size.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = wdata_in;
    case (mem_op_in[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << addr_in[1:0];
        wdata_fmt = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_fmt    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting: pick the lane from the captured offset, then extend.
  always_comb begin
    case (lo_q)
      2'd0:    rd_byte = dbus_rdata[7:0];
      2'd1:    rd_byte = dbus_rdata[15:8];
      2'd2:    rd_byte = dbus_rdata[23:16];
      default: rd_byte = dbus_rdata[31:24];
    endcase
    rd_half = lo_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (op_q)
      3'b000:  rdata_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rdata_fmt = {24'd0, rd_byte};
      3'b001:  rdata_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  rdata_fmt = {16'd0, rd_half};
      default: rdata_fmt = dbus_rdata;
    endcase
  end

  assign timeout = (cnt_q == CNT_LAST);

  // State register; asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (dbus_gnt) state_nxt = RSP;
      RSP:     if (dbus_rvalid || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control outputs.
  always_comb begin
    stall_out      = 1'b0;
    misalign_out   = 1'b0;
    dbus_req       = 1'b0;
    bus_err_out    = 1'b0;
    load_valid_out = 1'b0;
    case (state)
      IDLE: begin
        stall_out    = start;
        misalign_out = access & misaligned;
      end
      REQ: begin
        stall_out = 1'b1;
        dbus_req  = 1'b1;
      end
      RSP:  stall_out = 1'b1;
      DONE: begin
        bus_err_out    = err_q;
        load_valid_out = ~we_q & ~err_q;
      end
      default: ;
    endcase
  end

  // Bus fields are only presented while the request is up.
  assign dbus_we       = dbus_req & we_q;
  assign dbus_addr     = dbus_req ? addr_q  : 32'd0;
  assign dbus_be       = dbus_req ? be_q    : 4'd0;
  assign dbus_wdata    = dbus_req ? wdata_q : 32'd0;
  assign load_data_out = load_data_q;

  // Access capture, timeout counter, error flag and load result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q        <= 1'b0;
      lo_q        <= 2'd0;
      op_q        <= 3'd0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q    <= mem_wr_in;           // write wins when both requests are set
          lo_q    <= addr_in[1:0];
          op_q    <= mem_op_in;
          addr_q  <= {addr_in[31:2], 2'b00};
          be_q    <= be_fmt;
          wdata_q <= wdata_fmt;
          err_q   <= 1'b0;
        end
        REQ: if (dbus_gnt) cnt_q <= 8'd0;
        RSP: begin
          cnt_q <= cnt_q + 8'd1;
          if (dbus_rvalid) begin
            err_q <= dbus_err;
            if (dbus_err)   load_data_q <= 32'd0;   // failed access never exposes data
            else if (!we_q) load_data_q <= rdata_fmt;
          end else if (timeout) begin
            err_q       <= 1'b1;
            load_data_q <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
